pulse_stretch: RTL and testbench

- Output-side counterpart of the input debouncer. The debouncer filters short mechanical glitches from board buttons; this block stretches short internal strobes into human-visible LED blinks.
- Typical strobes are PC increment, PC load and halt.
- Each of CH channels turns a 1-cycle strobe into a fixed-length high pulse, followed by a guaranteed low gap, so back-to-back events stay visually distinct.
- Sits between core status strobes and board LED pins.

---
 rtl/pulse_stretch_pkg.sv | 30 +++
 rtl/pulse_stretch_ch.sv | 124 ++++++++++++
 rtl/pulse_stretch.sv | 45 ++++
 tb/tb_pulse_stretch.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pulse_stretch_pkg.sv
// Shared definitions for the LED pulse stretcher: state encoding, default
// timing constants and the elaboration-time parameter check.
package pulse_stretch_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_HOLD = ST_HOLD,
        S_GAP  = ST_GAP
    } state_t;

    localparam int unsigned DEF_CH   = 4;
    localparam int unsigned DEF_HOLD = 1024;
    localparam int unsigned DEF_GAP  = 256;
    localparam int unsigned DEF_CW   = 11;

    // True when HOLD/GAP are non-zero and both reloads fit in a cw-bit counter
    function automatic bit cw_ok(input int unsigned cw,
                                 input int unsigned hold,
                                 input int unsigned gap);
        longint unsigned cap;
        cap = 64'd1 << cw;
        return (hold >= 1) && (gap >= 1) &&
               (cap >= 64'(hold)) && (cap >= 64'(gap));
    endfunction

endpackage

// File: rtl/pulse_stretch_ch.sv
// One stretcher channel: turns a strobe into a HOLD-cycle high pulse followed
// by a GAP-cycle low gap, queues one extra event and flags lost ones.
// Build option: PULSE_STRETCH_RETRIGGER_EN makes events during HOLD extend
// the current blink instead of queueing.
module pulse_stretch_ch
    import pulse_stretch_pkg::*;
#(
    parameter int unsigned HOLD = DEF_HOLD,
    parameter int unsigned GAP  = DEF_GAP,
    parameter int unsigned CW   = DEF_CW
) (
    input  logic clk,
    input  logic n_reset,
    input  logic pulse_in,
    input  logic clr_drop,
    output logic led_out,
    output logic busy,
    output logic drop
);

    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(GAP - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          pending;

    // Channel FSM with counter, one-deep event queue and registered outputs
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            pending <= 1'b0;
            led_out <= 1'b0;
            busy    <= 1'b0;
            drop    <= 1'b0;
        end else begin
            // Clear first so a drop raised below in the same cycle wins
            if (clr_drop) begin
                drop <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (pulse_in) begin
                        state   <= S_HOLD;
                        cnt     <= HOLD_LD;
                        led_out <= 1'b1;
                        busy    <= 1'b1;
                    end else begin
                        led_out <= 1'b0;
                        busy    <= pending;
                    end
                end
                S_HOLD: begin
                    busy <= 1'b1;
`ifdef PULSE_STRETCH_RETRIGGER_EN
                    if (pulse_in) begin
                        cnt     <= HOLD_LD;
                        led_out <= 1'b1;
                    end else if (cnt == '0) begin
                        state   <= S_GAP;
                        cnt     <= GAP_LD;
                        led_out <= 1'b0;
                    end else begin
                        cnt     <= cnt - CW'(1);
                        led_out <= 1'b1;
                    end
`else
                    if (cnt == '0) begin
                        state   <= S_GAP;
                        cnt     <= GAP_LD;
                        led_out <= 1'b0;
                    end else begin
                        cnt     <= cnt - CW'(1);
                        led_out <= 1'b1;
                    end
                    if (pulse_in) begin
                        if (pending) begin
                            drop <= 1'b1;
                        end else begin
                            pending <= 1'b1;
                        end
                    end
`endif
                end
                S_GAP: begin
                    if (cnt == '0) begin
                        // Queued and fresh events on the last gap cycle share one blink
                        if (pending || pulse_in) begin
                            state   <= S_HOLD;
                            cnt     <= HOLD_LD;
                            pending <= 1'b0;
                            led_out <= 1'b1;
                            busy    <= 1'b1;
                        end else begin
                            state   <= S_IDLE;
                            led_out <= 1'b0;
                            busy    <= 1'b0;
                        end
                    end else begin
                        cnt     <= cnt - CW'(1);
                        led_out <= 1'b0;
                        busy    <= 1'b1;
                        if (pulse_in) begin
                            if (pending) begin
                                drop <= 1'b1;
                            end else begin
                                pending <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    cnt     <= '0;
                    pending <= 1'b0;
                    led_out <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pulse_stretch.sv
// Multi-channel LED pulse stretcher: CH independent channels sharing clock,
// reset and the drop-clear strobe.
// Build option: PULSE_STRETCH_RETRIGGER_EN (see pulse_stretch_ch).
module pulse_stretch
    import pulse_stretch_pkg::*;
#(
    parameter int unsigned CH   = DEF_CH,
    parameter int unsigned HOLD = DEF_HOLD,
    parameter int unsigned GAP  = DEF_GAP,
    parameter int unsigned CW   = DEF_CW
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic [CH-1:0] pulse_in,
    input  logic          clr_drop,
    output logic [CH-1:0] led_out,
    output logic [CH-1:0] busy,
    output logic [CH-1:0] drop
);

    localparam bit CFG_OK = cw_ok(CW, HOLD, GAP);

    // Reject parameter sets whose reload values do not fit the counter
    if (!CFG_OK) begin : g_bad_cfg
        $error("pulse_stretch: CW too small for HOLD/GAP, or HOLD/GAP is zero");
    end

    // One stretcher per channel, clr_drop fanned out to all of them
    for (genvar i = 0; i < int'(CH); i++) begin : g_ch
        pulse_stretch_ch #(
            .HOLD (HOLD),
            .GAP  (GAP),
            .CW   (CW)
        ) u_ch (
            .clk      (clk),
            .n_reset  (n_reset),
            .pulse_in (pulse_in[i]),
            .clr_drop (clr_drop),
            .led_out  (led_out[i]),
            .busy     (busy[i]),
            .drop     (drop[i])
        );
    end

endmodule

// File: tb/tb_pulse_stretch.sv
// Self-checking bench for pulse_stretch (CH=2, HOLD=4, GAP=2, CW=3):
// directed scenario table with explicit per-cycle masks, then random
// stimulus against a timestamp-based reference model.
module tb_pulse_stretch;

    localparam int CH   = 2;
    localparam int HOLD = 4;
    localparam int GAP  = 2;
    localparam int CW   = 3;

    logic          clk;
    logic          n_reset;
    logic [CH-1:0] pulse_in;
    logic          clr_drop;
    logic [CH-1:0] led_out;
    logic [CH-1:0] busy;
    logic [CH-1:0] drop;

    pulse_stretch #(
        .CH   (CH),
        .HOLD (HOLD),
        .GAP  (GAP),
        .CW   (CW)
    ) dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .pulse_in (pulse_in),
        .clr_drop (clr_drop),
        .led_out  (led_out),
        .busy     (busy),
        .drop     (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: each channel is a blink with absolute end times
    bit m_act  [CH];
    bit m_pend [CH];
    bit m_drop [CH];
    int m_hend [CH];
    int m_gend [CH];

    task automatic chk(input string name, input int c, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, c, got, exp);
        end
    endtask

    // Apply the inputs of cycle t to the model (effects visible at t+1)
    task automatic model_step(input logic [CH-1:0] p, input logic r, input logic c, input int t);
        for (int i = 0; i < CH; i++) begin
            bit lost;
            lost = 1'b0;
            if (!r) begin
                m_act[i]  = 1'b0;
                m_pend[i] = 1'b0;
                m_drop[i] = 1'b0;
            end else begin
                if (!m_act[i]) begin
                    if (p[i]) begin
                        m_act[i]  = 1'b1;
                        m_hend[i] = t + HOLD;
                        m_gend[i] = t + HOLD + GAP;
                    end
                end else if (t == m_gend[i]) begin
                    if (m_pend[i] || p[i]) begin
                        m_pend[i] = 1'b0;
                        m_hend[i] = t + HOLD;
                        m_gend[i] = t + HOLD + GAP;
                    end else begin
                        m_act[i] = 1'b0;
                    end
                end else if (p[i]) begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
                    if (t <= m_hend[i]) begin
                        m_hend[i] = t + HOLD;
                        m_gend[i] = t + HOLD + GAP;
                    end else if (m_pend[i]) lost = 1'b1;
                    else m_pend[i] = 1'b1;
`else
                    if (m_pend[i]) lost = 1'b1;
                    else m_pend[i] = 1'b1;
`endif
                end
                if (c) m_drop[i] = 1'b0;
                if (lost) m_drop[i] = 1'b1;
            end
        end
    endtask

    // One clock: drive inputs, advance model, sample at negedge and compare
    task automatic tick(input logic [CH-1:0] p, input logic r, input logic c);
        logic [CH-1:0] e_led, e_busy, e_drop;
        pulse_in = p;
        n_reset  = r;
        clr_drop = c;
        @(posedge clk);
        model_step(p, r, c, cyc);
        cyc++;
        @(negedge clk);
        for (int i = 0; i < CH; i++) begin
            e_led[i]  = m_act[i] && (cyc <= m_hend[i]);
            e_busy[i] = m_act[i] || m_pend[i];
            e_drop[i] = m_drop[i];
        end
        chk("model_led",  cyc, 32'(led_out), 32'(e_led));
        chk("model_busy", cyc, 32'(busy),    32'(e_busy));
        chk("model_drop", cyc, 32'(drop),    32'(e_drop));
    endtask

    function automatic bit [31:0] rng(input int lo, input int hi);
        bit [31:0] m;
        m = '0;
        for (int k = lo; k <= hi; k++) m[k] = 1'b1;
        return m;
    endfunction

    typedef struct {
        int        p0, p1, p2;
        int        rst_at;
        int        clr_at;
        bit [31:0] led;
        bit [31:0] busy;
        bit [31:0] drop;
    } scen_t;

    scen_t scen [6];
    int    n_scen;

    initial begin
        n_reset  = 1'b0;
        pulse_in = '0;
        clr_drop = 1'b0;
        for (int i = 0; i < CH; i++) begin
            m_act[i] = 0; m_pend[i] = 0; m_drop[i] = 0; m_hend[i] = 0; m_gend[i] = 0;
        end

        // Single blink
        scen[0] = '{10, -1, -1, -1, -1, rng(11, 14), rng(11, 16), 32'd0};
        // Second event queued during HOLD
        scen[1] = '{10, 12, -1, -1, -1, rng(11, 14) | rng(17, 20), rng(11, 22), 32'd0};
        // Third event dropped, then cleared
        scen[2] = '{10, 12, 13, -1, 25, rng(11, 14) | rng(17, 20), rng(11, 22), rng(14, 25)};
        // Reset mid-blink, then a fresh blink
        scen[3] = '{10, 15, -1, 12, -1, rng(11, 12) | rng(16, 19), rng(11, 12) | rng(16, 21), 32'd0};
        // Event on the last gap cycle chains straight into a new blink
        scen[4] = '{10, 16, -1, -1, -1, rng(11, 14) | rng(17, 20), rng(11, 22), 32'd0};
        n_scen = 5;
`ifdef PULSE_STRETCH_RETRIGGER_EN
        // Retrigger during HOLD extends the blink
        scen[5] = '{10, 13, -1, -1, -1, rng(11, 17), rng(11, 19), 32'd0};
        n_scen = 6;
`endif

        @(negedge clk);
        for (int s = 0; s < n_scen; s++) begin
            cyc = 0;
            for (int t = 0; t < 30; t++) begin
                logic p0;
                p0 = (t == scen[s].p0) || (t == scen[s].p1) || (t == scen[s].p2);
                tick({1'b0, p0}, !((t == 0) || (t == scen[s].rst_at)), t == scen[s].clr_at);
                chk($sformatf("s%0d_led0", s),  cyc, 32'(led_out[0]), 32'(scen[s].led[cyc]));
                chk($sformatf("s%0d_busy0", s), cyc, 32'(busy[0]),    32'(scen[s].busy[cyc]));
                chk($sformatf("s%0d_drop0", s), cyc, 32'(drop[0]),    32'(scen[s].drop[cyc]));
                chk($sformatf("s%0d_ch1", s),   cyc, 32'({led_out[1], busy[1], drop[1]}), 32'd0);
            end
        end

        // Random traffic on both channels against the model
        cyc = 0;
        tick('0, 1'b0, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            logic [CH-1:0] p;
            for (int i = 0; i < CH; i++) p[i] = ($urandom_range(0, 2) == 0);
            if (n % 500 < 40) p = '1;
            tick(p, $urandom_range(0, 127) != 0, $urandom_range(0, 15) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
